// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stage indices, stall bus width,
// sequencer state encoding and common constants.
package pipe_ctrl_pkg;

    localparam int StallBus  = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_IDLE     = 2'b00,
        PC_DIV_WAIT = 2'b01,
        PC_DIV_DONE = 2'b10,
        PC_FLUSH    = 2'b11
    } pc_state_e;

    // Hold every stage from PC up to and including 'top'.
    function automatic logic [StallBus-1:0] stall_upto(input int top);
        logic [StallBus-1:0] m;
        for (int i = 0; i < StallBus; i++) m[i] = (i <= top);
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush/divider handshake bundle between the pipeline stages and
// the central sequencer.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                stallreq_if_i;
    logic                stallreq_id_i;
    logic                ex_div_req_i;
    logic                div_ready_i;
    logic                div_start_o;
    logic                div_annul_o;
    logic                flush_req_i;
    logic [31:0]         new_pc_i;
    logic [StallBus-1:0] stall_o;
    logic                flush_o;
    logic [31:0]         new_pc_o;
    logic                div_busy_o;
    logic                div_timeout_o;

    modport slave (
        input  stallreq_if_i, stallreq_id_i, ex_div_req_i, div_ready_i,
               flush_req_i, new_pc_i,
        output div_start_o, div_annul_o, stall_o, flush_o, new_pc_o,
               div_busy_o, div_timeout_o
    );

    modport master (
        output stallreq_if_i, stallreq_id_i, ex_div_req_i, div_ready_i,
               flush_req_i, new_pc_i,
        input  div_start_o, div_annul_o, stall_o, flush_o, new_pc_o,
               div_busy_o, div_timeout_o
    );

endinterface

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer: merges IF/ID stall requests, runs the
// divider start/ready/annul handshake and registers MEM flush redirects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    pc_state_e           state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         new_pc_q;
    logic                annul_q;
    logic                timeout_q;
    logic [StallBus-1:0] stall_d;
    logic                start_d;
    logic                idle;

    assign idle = (state_q == PC_IDLE);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= PC_IDLE;
            cnt_q     <= '0;
            new_pc_q  <= ZeroWord;
            annul_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            annul_q <= 1'b0;
            if (bus.flush_req_i) new_pc_q <= bus.new_pc_i;
            case (state_q)
                PC_IDLE: begin
                    if (bus.flush_req_i) begin
                        state_q <= PC_FLUSH;
                    end else if (bus.ex_div_req_i) begin
                        state_q <= PC_DIV_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PC_DIV_WAIT: begin
                    if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                    // A flush abandons the divide even if the result just arrived.
                    if (bus.flush_req_i) begin
                        state_q <= PC_FLUSH;
                        annul_q <= 1'b1;
                    end else if (bus.div_ready_i) begin
                        state_q <= PC_DIV_DONE;
                    end else if (cnt_q == CNT_W'(DIV_TIMEOUT - 1)) begin
                        state_q   <= PC_IDLE;
                        annul_q   <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                PC_DIV_DONE, PC_FLUSH: begin
                    state_q <= bus.flush_req_i ? PC_FLUSH : PC_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = '0;
        if (!bus.flush_req_i && state_q != PC_FLUSH) begin
            if ((idle && bus.ex_div_req_i) || state_q == PC_DIV_WAIT)
                stall_d = stall_upto(STALL_EX);
            else if (bus.stallreq_id_i)
                stall_d = stall_upto(STALL_ID);
            else if (bus.stallreq_if_i)
                stall_d = stall_upto(STALL_IF);
        end
    end

    // Zero-latency start: the divider runs in the same cycle EX asks.
    assign start_d = (state_q == PC_DIV_WAIT) ||
                     (idle && bus.ex_div_req_i && !bus.flush_req_i);

    assign bus.stall_o       = rst ? '0 : stall_d;
    assign bus.div_start_o   = rst ? 1'b0 : start_d;
    assign bus.flush_o       = rst ? 1'b0 : (state_q == PC_FLUSH);
    assign bus.div_annul_o   = rst ? 1'b0 : annul_q;
    assign bus.new_pc_o      = rst ? ZeroWord : new_pc_q;
    assign bus.div_busy_o    = rst ? 1'b0 : (state_q == PC_DIV_WAIT);
    assign bus.div_timeout_o = rst ? 1'b0 : timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, all checked
// against a cycle-level behavioural model of the sequencer rules.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

    pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Model: what the sequencer is doing, in plain terms.
    bit          m_dividing, m_done, m_flushing, m_annul, m_timeout;
    int          m_waited;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit sif, input bit sid, input bit exd,
                          input bit rdy, input bit fl, input logic [31:0] pc);
        rst               = r;
        bus.stallreq_if_i = sif;
        bus.stallreq_id_i = sid;
        bus.ex_div_req_i  = exd;
        bus.div_ready_i   = rdy;
        bus.flush_req_i   = fl;
        bus.new_pc_i      = pc;
    endtask

    task automatic model_reset();
        m_dividing = 0; m_done = 0; m_flushing = 0;
        m_annul = 0; m_timeout = 0; m_waited = 0; m_pc = 32'h0;
    endtask

    // Check all outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit          idle;
        logic [5:0]  es;
        bit          est;
        @(negedge clk);
        idle = !m_dividing && !m_done && !m_flushing;
        if (bus.flush_req_i || m_flushing)             es = 6'b000000;
        else if ((idle && bus.ex_div_req_i) || m_dividing) es = 6'b001111;
        else if (bus.stallreq_id_i)                    es = 6'b000111;
        else if (bus.stallreq_if_i)                    es = 6'b000011;
        else                                           es = 6'b000000;
        est = m_dividing || (idle && bus.ex_div_req_i && !bus.flush_req_i);
        chk("stall_o",       32'(bus.stall_o),       rst ? 32'd0 : 32'(es));
        chk("div_start_o",   32'(bus.div_start_o),   rst ? 32'd0 : 32'(est));
        chk("flush_o",       32'(bus.flush_o),       rst ? 32'd0 : 32'(m_flushing));
        chk("div_annul_o",   32'(bus.div_annul_o),   rst ? 32'd0 : 32'(m_annul));
        chk("new_pc_o",      bus.new_pc_o,           rst ? 32'd0 : m_pc);
        chk("div_busy_o",    32'(bus.div_busy_o),    rst ? 32'd0 : 32'(m_dividing));
        chk("div_timeout_o", 32'(bus.div_timeout_o), rst ? 32'd0 : 32'(m_timeout));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_annul = 0;
            if (bus.flush_req_i) begin
                m_annul    = m_dividing;
                m_dividing = 0; m_done = 0; m_flushing = 1;
                m_pc       = bus.new_pc_i;
            end else if (m_dividing) begin
                m_waited++;
                if (bus.div_ready_i) begin
                    m_dividing = 0; m_done = 1;
                end else if (m_waited == TO) begin
                    m_dividing = 0; m_annul = 1; m_timeout = 1;
                end
            end else begin
                m_done = 0; m_flushing = 0;
                if (idle && bus.ex_div_req_i) begin
                    m_dividing = 1; m_waited = 0;
                end
            end
        end
        #1;
    endtask

    // Divide that completes with ready at cycle 34 (request at cycle 0).
    task automatic normal_div();
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        chk("div_busy_c1", 32'(bus.div_busy_o), 32'd1);
        for (int c = 1; c < 34; c++) step();
        set_in(0, 0, 0, 1, 1, 0, 0);
        step();
        chk("div_done_stall", 32'(bus.stall_o), 32'd0);
        chk("div_done_start", 32'(bus.div_start_o), 32'd0);
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("div_idle_busy", 32'(bus.div_busy_o), 32'd0);
    endtask

    initial begin
        model_reset();
        set_in(1, 0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("rst_stall", 32'(bus.stall_o), 32'd0);

        // Stall priority between IF and ID requests.
        set_in(0, 1, 0, 0, 0, 0, 0); step();
        set_in(0, 1, 1, 0, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0); step();

        normal_div();

        // Flush during a divide.
        set_in(0, 0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 6; c++) step();
        set_in(0, 0, 0, 1, 0, 1, 32'h0000_0020);
        step();
        chk("fl_flush_o", 32'(bus.flush_o), 32'd1);
        chk("fl_new_pc",  bus.new_pc_o, 32'h0000_0020);
        chk("fl_annul",   32'(bus.div_annul_o), 32'd1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("fl_done", 32'(bus.flush_o | bus.div_annul_o), 32'd0);
        step();

        // Timeout: 40 wait cycles with no ready.
        set_in(0, 0, 0, 1, 0, 0, 0);
        for (int c = 0; c < TO; c++) step();
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("to_annul",   32'(bus.div_annul_o), 32'd1);
        chk("to_sticky",  32'(bus.div_timeout_o), 32'd1);
        chk("to_idle",    32'(bus.div_busy_o), 32'd0);
        step();
        chk("to_annul_1", 32'(bus.div_annul_o), 32'd0);
        chk("to_hold",    32'(bus.div_timeout_o), 32'd1);

        // Flush, divide request and ID stall together in IDLE.
        set_in(0, 0, 1, 1, 0, 1, 32'h0000_0044);
        step();
        chk("sim_flush", 32'(bus.flush_o), 32'd1);
        chk("sim_busy",  32'(bus.div_busy_o), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();

        // Reset in the middle of a divide.
        set_in(0, 0, 0, 1, 0, 0, 0);
        for (int c = 0; c < 11; c++) step();
        set_in(1, 0, 0, 1, 0, 0, 0);
        step();
        chk("rst_mid_tmo",   32'(bus.div_timeout_o), 32'd0);
        chk("rst_mid_annul", 32'(bus.div_annul_o), 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        normal_div();

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            set_in(($urandom_range(199) == 0), ($urandom_range(3) == 0),
                   ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                   ($urandom_range(5) == 0), ($urandom_range(15) == 0), $urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS32 pipeline (PC, IF, ID, EX, MEM, WB).
- Merges stall requests from IF and ID, which cover load-use hazards that ID forwarding cannot resolve.
- Runs the start/ready/annul handshake with the multi-cycle divider in EX.
- Registers exception/flush redirects from MEM and drives the per-stage stall vector plus flush strobe to every pipeline register.

Parameters:
- DIV_TIMEOUT, 40, max DIV_WAIT cycles before the divide is abandoned (must be >= 2).
- CNT_W, 6, width of the wait counter (2**CNT_W > DIV_TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- stallreq_if_i  in  1  IF stall request (instruction fetch not ready).
- stallreq_id_i  in  1  ID stall request (load-use hazard).
- ex_div_req_i  in  1  EX holds DIV/DIVU needing the divider.
- div_ready_i  in  1  divider result valid this cycle.
- div_start_o  out  1  divider run enable, level.
- div_annul_o  out  1  one-cycle abort pulse to the divider.
- flush_req_i  in  1  MEM requests a pipeline flush (exception/eret).
- new_pc_i  in  32  redirect target, sampled with flush_req_i.
- stall_o  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush_o  out  1  one-cycle flush of all pipeline registers.
- new_pc_o  out  32  registered redirect target, valid while flush_o = 1.
- div_busy_o  out  1  state == DIV_WAIT.
- div_timeout_o  out  1  sticky; set on divide timeout, cleared only by rst.

Behaviour:
- Reset, when rst = 1 at a rising edge:
  - state = IDLE, counter = 0, div_timeout_o = 0, new_pc_o = 0.
  - While rst is high, all outputs are forced to 0, including stall_o = 6'b000000.
- States: IDLE, DIV_WAIT, DIV_DONE, FLUSH. State, counter, new_pc_o, flush_o and div_annul_o are registered. stall_o and div_start_o are combinational from state and inputs.
- stall_o priority, highest first:
  1. flush_req_i = 1 -> 6'b000000.
  2. state == FLUSH -> 6'b000000.
  3. state == IDLE and ex_div_req_i, or state == DIV_WAIT -> 6'b001111.
  4. stallreq_id_i -> 6'b000111.
  5. stallreq_if_i -> 6'b000011.
  6. Otherwise -> 6'b000000.
  - Stalls are contiguous from PC upward; WB is never held.
- div_start_o = 1 in DIV_WAIT, and in IDLE when ex_div_req_i = 1 and flush_req_i = 0. This gives zero-latency start.
- IDLE:
  - flush_req_i -> FLUSH. flush_req_i wins over ex_div_req_i.
  - Else ex_div_req_i -> DIV_WAIT with counter = 0.
- DIV_WAIT:
  - Counter increments each cycle.
  - flush_req_i -> FLUSH, with div_annul_o = 1 on the next cycle.
  - Else div_ready_i -> DIV_DONE.
  - Else counter == DIV_TIMEOUT-1 -> IDLE, div_annul_o = 1 on the next cycle, div_timeout_o set.
  - flush_req_i and div_ready_i in the same cycle: flush wins, result discarded, annul issued.
- DIV_DONE:
  - Lasts one cycle. stall_o = 0 so EX/MEM captures the quotient/remainder. div_start_o = 0.
  - ex_div_req_i is ignored here because the same instruction is still leaving EX.
  - flush_req_i -> FLUSH; else -> IDLE.
- FLUSH:
  - Entered on the edge where flush_req_i = 1. new_pc_o <= new_pc_i on that edge, and flush_o = 1 for exactly this one cycle.
  - Next state is IDLE.
  - A flush_req_i arriving during FLUSH re-enters FLUSH and reloads new_pc_o. Back-to-back exceptions are legal.
- The counter saturates and never wraps. It is cleared on every entry to DIV_WAIT.
- div_ready_i outside DIV_WAIT is ignored.
- Asserting rst mid-divide returns to IDLE with no annul pulse. The divider is reset by the same rst.

Decomposition:
- Shared package or header (cpu_defines):
  - Stage index constants: STALL_PC = 0 through STALL_WB = 5.
  - Stall vector width StallBus = 6.
  - State encodings: PC_IDLE = 2'b00, PC_DIV_WAIT = 2'b01, PC_DIV_DONE = 2'b10, PC_FLUSH = 2'b11.
  - Existing RstEnable and ZeroWord constants.
- No sub-module: the FSM, counter and stall priority mux are one block of about 180 lines.

Test Plan:
1. Priority: stallreq_if_i = 1 alone -> stall_o = 6'b000011. Add stallreq_id_i -> 6'b000111. Release both -> 6'b000000 in the same cycle.
2. Normal divide: ex_div_req_i = 1 at cycle 0 -> stall_o = 6'b001111 and div_start_o = 1 at cycle 0. With div_ready_i = 1 at cycle 34 -> stall_o = 0 and div_start_o = 0 at cycle 35 (DIV_DONE), IDLE at cycle 36. div_busy_o high for cycles 1 to 34.
3. Flush during divide: in DIV_WAIT, flush_req_i = 1 with new_pc_i = 32'h0000_0020 -> next cycle flush_o = 1, new_pc_o = 32'h20, div_annul_o = 1, stall_o = 0. The cycle after that: IDLE, with flush_o and div_annul_o back to 0.
4. Timeout with DIV_TIMEOUT = 40 and div_ready_i held 0 -> after 40 DIV_WAIT cycles: div_annul_o pulses once, div_timeout_o = 1 and stays 1, state returns to IDLE.
5. Simultaneous events in IDLE: flush_req_i = 1, ex_div_req_i = 1 and stallreq_id_i = 1 together -> stall_o = 0 and div_start_o = 0. Next cycle flush_o = 1 and the state is FLUSH, not DIV_WAIT.
6. Reset mid-operation: rst = 1 in DIV_WAIT at counter = 10 -> after the edge all outputs are 0 and div_timeout_o = 0. After rst = 0, a fresh divide completes normally, as in test 2.
